universal_shift_burst: RTL and testbench

Parametrised universal shift register with hold, shift-right, shift-left and parallel-load modes, plus a self-timed burst engine that performs N back-to-back shifts on one command. It succeeds the fixed 4-bit serial-in/serial-out register in the shift-register library. It serves as the common serializer/deserializer primitive for the datapath blocks.

---
 rtl/universal_shift_burst.sv | 114 +++++++++++
 tb/tb_universal_shift_burst.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_burst.sv
// universal_shift_burst
//   Parametrised universal shift register (hold / shift right / shift left /
//   parallel load) with a self-timed burst engine that performs N
//   back-to-back shifts in one direction on a single command.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           enables mode operation while idle
//   mode         00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r        serial input entering at the MSB on right shifts
//   sin_l        serial input entering at the LSB on left shifts
//   pin          parallel load data
//   burst_start  request an N-shift burst (accepted only while idle)
//   burst_len    number of shifts N, sampled with burst_start
//   burst_dir    0 = right, 1 = left, sampled with burst_start
//   q            register contents
//   sout_r       q[0], serial out for right shifts
//   sout_l       q[WIDTH-1], serial out for left shifts
//   busy         burst in progress
//   done         one-cycle burst-complete pulse
//
// Handshake: burst_start is a single-cycle request that is honoured only
// when busy=0; a request seen while busy=1 is dropped, never queued.
// Completion is signalled by done=1 for exactly one cycle.
module universal_shift_burst #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [0:0]       state;
    logic [LEN_W-1:0] cnt;
    logic             dir;

    logic [WIDTH-1:0] q_right;
    logic [WIDTH-1:0] q_left;

    assign q_right = {sin_r, q[WIDTH-1:1]};
    assign q_left  = {q[WIDTH-2:0], sin_l};

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign busy   = (state == BURST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            // done is a pulse: cleared on every edge unless re-raised below.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        // q is left untouched on the accepting edge.
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            cnt   <= burst_len;
                            dir   <= burst_dir;
                            state <= BURST;
                        end
                    end else if (en) begin
                        case (mode)
                            MODE_RIGHT: q <= q_right;
                            MODE_LEFT:  q <= q_left;
                            MODE_LOAD:  q <= pin;
                            MODE_HOLD:  q <= q;
                            default:    q <= q;
                        endcase
                    end
                end
                BURST: begin
                    q   <= dir ? q_left : q_right;
                    cnt <= cnt - 1'b1;
                    // cnt==1 means this edge performs the final shift.
                    if (cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_burst.sv
module tb_universal_shift_burst;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic             burst_start;
    logic [LEN_W-1:0] burst_len;
    logic             burst_dir;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    universal_shift_burst #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
        .burst_start(burst_start), .burst_len(burst_len), .burst_dir(burst_dir),
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    // driver tasks: advance one edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = 2'b11; pin = v;
        tick();
        en = 1'b0; mode = 2'b00;
        check("load", 32'(q), 32'(v));
    endtask

    logic [7:0] exp_q;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
        pin = '0; burst_start = 1'b0; burst_len = '0; burst_dir = 1'b0;

        // reset and load
        tick(); tick();
        check_st("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        en = 1'b1; mode = 2'b11; pin = 8'hA5;
        tick();
        check("load_a5", 32'(q), 32'hA5);
        check("sout_r", 32'(sout_r), 32'h1);
        check("sout_l", 32'(sout_l), 32'h1);

        // single shifts and hold
        mode = 2'b01; sin_r = 1'b0;
        tick();
        check("shr", 32'(q), 32'h52);
        check("sout_r_52", 32'(sout_r), 32'h0);
        mode = 2'b10; sin_l = 1'b1;
        tick();
        check("shl", 32'(q), 32'hA5);
        mode = 2'b00;
        tick();
        check("hold_mode", 32'(q), 32'hA5);
        en = 1'b0; mode = 2'b01;
        tick(); tick();
        check("hold_en0", 32'(q), 32'hA5);

        // right burst of 3
        load(8'h81);
        burst_start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0; sin_r = 1'b0;
        tick();
        burst_start = 1'b0;
        check_st("rb_acc", 8'h81, 1'b1, 1'b0);
        tick(); check_st("rb_1", 8'h40, 1'b1, 1'b0);
        tick(); check_st("rb_2", 8'h20, 1'b1, 1'b0);
        tick(); check_st("rb_3", 8'h10, 1'b0, 1'b1);
        tick(); check_st("rb_after", 8'h10, 1'b0, 1'b0);

        // long left burst of 10 with ignored inputs mid-burst
        load(8'hFF);
        burst_start = 1'b1; burst_len = 4'd10; burst_dir = 1'b1; sin_l = 1'b0;
        tick();
        burst_start = 1'b0;
        check_st("lb_acc", 8'hFF, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                burst_start = 1'b1; burst_len = 4'd1; burst_dir = 1'b0;
                en = 1'b1; mode = 2'b11; pin = 8'h5A;
            end else begin
                burst_start = 1'b0; en = 1'b0; mode = 2'b00;
            end
            tick();
            exp_q = (i >= 8) ? 8'h00 : 8'(8'hFF << i);
            check_st($sformatf("lb_%0d", i), exp_q, (i < 10), (i == 10));
        end
        burst_start = 1'b0; en = 1'b0; mode = 2'b00;
        tick(); check_st("lb_after", 8'h00, 1'b0, 1'b0);

        // zero-length burst, then restart on the done cycle
        load(8'h3C);
        burst_start = 1'b1; burst_len = 4'd0; burst_dir = 1'b0;
        tick();
        check_st("zb_done", 8'h3C, 1'b0, 1'b1);
        burst_len = 4'd1; sin_r = 1'b1;
        tick();
        burst_start = 1'b0;
        check_st("zb_restart", 8'h3C, 1'b1, 1'b0);
        tick(); check_st("zb_shift", 8'h9E, 1'b0, 1'b1);
        tick(); check_st("zb_after", 8'h9E, 1'b0, 1'b0);

        // reset mid-burst, then a full burst
        load(8'hF0);
        burst_start = 1'b1; burst_len = 4'd6; burst_dir = 1'b0; sin_r = 1'b1;
        tick();
        burst_start = 1'b0;
        tick(); check_st("mr_1", 8'hF8, 1'b1, 1'b0);
        tick(); check_st("mr_2", 8'hFC, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(); check_st("mr_rst", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); check_st("mr_nodone", 8'h00, 1'b0, 1'b0);
        burst_start = 1'b1; burst_len = 4'd4; burst_dir = 1'b1; sin_l = 1'b1;
        tick();
        burst_start = 1'b0;
        check_st("fb_acc", 8'h00, 1'b1, 1'b0);
        tick(); check_st("fb_1", 8'h01, 1'b1, 1'b0);
        tick(); check_st("fb_2", 8'h03, 1'b1, 1'b0);
        tick(); check_st("fb_3", 8'h07, 1'b1, 1'b0);
        tick(); check_st("fb_4", 8'h0F, 1'b0, 1'b1);
        tick(); check_st("fb_after", 8'h0F, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
